gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Synchronises and debounces the raw push-button and vehicle-sensor lines coming off the DE10-Nano header before they reach the HPS-readable input PIO bank. It sits directly upstream of the PIO. Its debounced level bus drives the PIO `in_port`, so software only ever sees clean, glitch-free levels. Per-bit rise and fall strobes are also produced for fabric-side logic such as pedestrian-request latching.

## Interface

Parameters:
- `WIDTH`, 6: number of input lines; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a level change is accepted. Default is 1 ms at 50 MHz. Legal range is 2 to 2^20.
- `RESET_LEVEL`, 1'b0: value loaded into every `clean_out` bit at reset.

Ports:
- `clk`, input, 1: system clock. Single clock domain; every register is clocked on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `raw_in`, input, WIDTH: asynchronous raw pin levels.
- `clean_out`, output, WIDTH: registered debounced levels; connects to the PIO `in_port`.
- `rise_pulse`, output, WIDTH: one-cycle strobe per bit when the `clean_out` bit goes 0 to 1.
- `fall_pulse`, output, WIDTH: one-cycle strobe per bit when the `clean_out` bit goes 1 to 0.

## Operation

- **Per-bit synchroniser:** a chain of flops on each `raw_in` bit, 2 stages by default (see Configuration). The last stage output is called `s`.
- **Per-bit debounce counter:** width is CW = $clog2(DEBOUNCE_CYCLES).
- **Counter behaviour, evaluated every cycle:**
  - If `s` == `clean_out` bit, the counter is cleared to 0.
  - If `s` != `clean_out` bit and the counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If `s` != `clean_out` bit and the counter == DEBOUNCE_CYCLES-1, the `clean_out` bit toggles and the counter clears to 0.
- **Glitch rejection:** any single cycle where `s` == `clean_out` restarts the count. Glitches shorter than DEBOUNCE_CYCLES are therefore fully rejected.
- **Strobes:**
  - `rise_pulse[i]` and `fall_pulse[i]` are registered.
  - Each is high for exactly the one cycle in which the new `clean_out[i]` value first appears.
  - They are never both high for the same bit.
- **Bit independence:** bits are fully independent. Simultaneous changes on several bits each follow their own counter. Any combination of strobes may assert in the same cycle.
- **Counter overflow:** impossible, because the counter never exceeds DEBOUNCE_CYCLES-1.

## Timing

- **Reset values:**
  - Synchroniser flops load RESET_LEVEL.
  - Counters load 0.
  - `clean_out` = {WIDTH{RESET_LEVEL}}.
  - `rise_pulse` = 0 and `fall_pulse` = 0.
  - Outputs take these values immediately on `reset_n` low and hold them while it is low.
- **Latency:** `raw_in` is changed before rising edge 1 and then held steady.
  - `s` reflects the new value after edge N, where N is the synchroniser depth.
  - `clean_out` and the strobe change at edge N + DEBOUNCE_CYCLES.
  - With the 2-stage default that is edge 2 + DEBOUNCE_CYCLES.
- **Minimum accepted pulse:** a `raw_in` pulse is accepted if it is stable for DEBOUNCE_CYCLES sampling edges. Shorter pulses never reach `clean_out`.
- **Reset mid-count:** any partial count is discarded. After release, a `raw_in` level differing from RESET_LEVEL needs the full N + DEBOUNCE_CYCLES edges before it appears. No strobe is emitted by reset itself.
- **Reset release with `raw_in` == RESET_LEVEL:** no output activity.
- **Throughput:** one accepted transition per bit per DEBOUNCE_CYCLES cycles, at most.

## Configuration

- Macro: `GPIO_INPUT_CONDITIONER_SYNC3_EN`.
- Defined: the synchroniser is 3 flops deep (N = 3). All latencies above gain one cycle.
- Undefined: the synchroniser is 2 flops deep (N = 2).
- Debounce behaviour and reset values are otherwise identical in both builds.

## Test plan

All scenarios use WIDTH=6, DEBOUNCE_CYCLES=4 and RESET_LEVEL=0, with the macro undefined unless stated.

- **Reset:** assert `reset_n`=0 with `raw_in`=6'h3F.
  - While reset is held: `clean_out`=0, with no strobes.
  - After release with `raw_in` held at 6'h3F: `clean_out`=6'h3F at edge 6, and `rise_pulse`=6'h3F for exactly that cycle.
- **Single bit, macro undefined:** `raw_in[0]` goes 0 to 1 before edge 1 and is held.
  - `clean_out[0]`=1 and `rise_pulse[0]`=1 at edge 6.
  - `rise_pulse` is 0 again at edge 7.
  - Other bits are unchanged.
- **Glitch rejection:**
  - A 3-cycle high pulse on `raw_in[2]` leaves `clean_out[2]`=0 and produces no `rise_pulse`.
  - A 4-cycle high pulse is accepted.
  - After 2 cycles high, 1 low, then 4 high, `clean_out[2]` rises 4 edges after `s` returns high.
- **Simultaneous bits:** `raw_in[1]` rises and `raw_in[4]` falls (from clean 1) on the same edge.
  - At edge 6: `rise_pulse`=6'h02 and `fall_pulse`=6'h10 in the same cycle.
- **Reset mid-count:** `raw_in[3]` is high for 4 edges, then `reset_n` is pulsed low for 1 cycle.
  - `clean_out[3]` stays 0 through the reset and rises 6 edges after release.
- **Macro defined:** repeat the single-bit scenario; `clean_out[0]` rises at edge 7.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Per-bit synchroniser and debouncer feeding the HPS input PIO, with registered rise/fall strobes.
// Define GPIO_INPUT_CONDITIONER_SYNC3_EN for a 3-flop synchroniser (default is 2 flops).
module gpio_input_conditioner #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
`ifdef GPIO_INPUT_CONDITIONER_SYNC3_EN
  localparam int unsigned SYNC_STAGES = 3;
`else
  localparam int unsigned SYNC_STAGES = 2;
`endif
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  toggle;
  logic [WIDTH-1:0]                  clean_q;
  logic [WIDTH-1:0]                  rise_q;
  logic [WIDTH-1:0]                  fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{{WIDTH{RESET_LEVEL}}}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Each bit counts consecutive cycles of disagreement; any agreeing cycle restarts it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign toggle[i] = (s[i] != clean_q[i]) && (cnt_q == CNT_MAX);

    always_comb begin
      cnt_d = '0;
      if ((s[i] != clean_q[i]) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Strobes are registered alongside clean_q so they coincide with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_q <= {WIDTH{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      clean_q <= clean_q ^ toggle;
      rise_q  <= toggle & ~clean_q;
      fall_q  <= toggle & clean_q;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus random pin activity,
// checked cycle by cycle against a run-length debounce model through an expected queue.
module tb_gpio_input_conditioner;
  localparam int W = 6;
  localparam int D = 4;
  localparam logic RL = 1'b0;
`ifdef GPIO_INPUT_CONDITIONER_SYNC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  gpio_input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .RESET_LEVEL    (RL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [3*W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // s_line holds the pin words still in flight through the synchroniser (oldest first).
  logic [W-1:0] s_line[$];
  logic [W-1:0] m_clean;
  int           run[W];

  function automatic void model_reset();
    s_line.delete();
    for (int k = 0; k < N; k++) s_line.push_back({W{RL}});
    m_clean = {W{RL}};
    for (int i = 0; i < W; i++) run[i] = 0;
  endfunction

  // One rising edge: a bit accepts a new level once it has seen D consecutive
  // samples differing from its clean level; acceptance restarts the run.
  function automatic logic [3*W-1:0] model_edge(input logic [W-1:0] raw);
    logic [W-1:0] s;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    s = s_line.pop_front();
    s_line.push_back(raw);
    rise = '0;
    fall = '0;
    for (int i = 0; i < W; i++) begin
      run[i] = (s[i] != m_clean[i]) ? run[i] + 1 : 0;
      if (run[i] == D) begin
        run[i]     = 0;
        m_clean[i] = s[i];
        if (s[i]) rise[i] = 1'b1;
        else      fall[i] = 1'b1;
      end
    end
    return {m_clean, rise, fall};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic [W-1:0] raw);
    reset_n = rn;
    raw_in  = raw;
    if (!rn) model_reset();
    @(posedge clk);
    if (rn) exp_q.push_back(model_edge(raw));
    else    exp_q.push_back({{W{RL}}, {(2*W){1'b0}}});
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic rn, input logic [W-1:0] raw, input int cycles);
    for (int c = 0; c < cycles; c++) step(rn, raw);
  endtask

  // ---------------- monitor ----------------
  logic [3*W-1:0] mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_vec++;
        if ({clean_out, rise_pulse, fall_pulse} !== mon_exp) begin
          n_err++;
          $display("FAIL cycle_check t=%0t got clean=%h rise=%h fall=%h required clean=%h rise=%h fall=%h",
                   $time, clean_out, rise_pulse, fall_pulse,
                   mon_exp[3*W-1:2*W], mon_exp[2*W-1:W], mon_exp[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] r;
  int           hold_left[W];

  initial begin
    // Reset with all pins high, then release and hold.
    hold(1'b0, 6'h3F, 3);
    hold(1'b1, 6'h3F, 8);

    // Single bit rising from an all-low state.
    hold(1'b0, 6'h00, 2);
    hold(1'b1, 6'h00, 3);
    hold(1'b1, 6'h01, 8);

    // Glitches on bit 2: 3-cycle rejected, 4-cycle accepted, then 2-high/1-low/4-high.
    hold(1'b1, 6'h05, 3);
    hold(1'b1, 6'h01, 6);
    hold(1'b1, 6'h05, 4);
    hold(1'b1, 6'h01, 8);
    hold(1'b1, 6'h05, 2);
    hold(1'b1, 6'h01, 1);
    hold(1'b1, 6'h05, 8);

    // Simultaneous rise on bit 1 and fall on bit 4.
    hold(1'b1, 6'h10, 8);
    hold(1'b1, 6'h02, 8);

    // Reset in the middle of a count on bit 3.
    hold(1'b0, 6'h00, 2);
    hold(1'b1, 6'h00, 3);
    hold(1'b1, 6'h08, 4);
    hold(1'b0, 6'h08, 1);
    hold(1'b1, 6'h08, 8);

    // Random pin activity with occasional reset pulses.
    r = '0;
    for (int i = 0; i < W; i++) hold_left[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold_left[i] == 0) begin
          r[i]         = 1'($urandom_range(0, 1));
          hold_left[i] = $urandom_range(1, 7);
        end
        hold_left[i]--;
      end
      if ($urandom_range(0, 149) == 0) step(1'b0, r);
      else                             step(1'b1, r);
    end
    hold(1'b1, r, 12);

    @(posedge clk);
    #5;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d pending entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
